mealy_frame_collector: RTL
==========================

// Module: mealy_frame_collector
// PURPOSE
//  Controller behind the serial strobe/data Mealy decoder.
//  Takes the decoder's per-bit strobe (R) and bit value (Y) and assembles WIDTH bits into a word.
//  Hands the word to a consumer with a Valid/Ready handshake.
//  Discards stalled frames on inter-bit timeout and flags bits lost while a word is held.
// PARAMETERS
//  WIDTH    8    bits per frame; legal range 2..16
//  TIMEOUT  255  max clock cycles between strobes inside a frame; legal range 1..65535
//  MSB_FIRST 1   1: first received bit lands in Data[WIDTH-1]; 0: first bit lands in Data[0]
// PORTS
//  C        in   1      clock, rising edge
//  aR       in   1      asynchronous reset, active-high
//  BitR     in   1      bit strobe from the decoder, one cycle per bit
//  BitY     in   1      bit value; sampled ONLY when BitR=1, may be X otherwise
//  Clr      in   1      synchronous abort: drops the partial frame and Valid, clears Overrun
//  Data     out  WIDTH  assembled word; stable while Valid=1
//  Valid    out  1      word available
//  Ready    in   1      consumer accepts the word when Valid&Ready
//  Busy     out  1      1 in COLLECT (partial frame in progress)
//  Count    out  5      bits collected in the current frame, 0..WIDTH-1
//  Overrun  out  1      sticky: a strobe was dropped in HOLD
//  TimeoutP out  1      one-cycle pulse: partial frame discarded on timeout
// BEHAVIOUR
//  Reset (aR=1, any time): state IDLE, Data=0, Valid=0, Busy=0, Count=0, Overrun=0,
//   TimeoutP=0, shift register=0, timer=0. Mid-frame reset discards everything.
//  All outputs are registered.
//  States: IDLE, COLLECT, HOLD. Priority per edge: aR > Clr > timeout > strobe/handshake.
//  IDLE:
//   - BitR=1: shift in BitY, Count=1, timer=0, go to COLLECT.
//  COLLECT, each cycle:
//   - BitR=0: timer+1. When timer reaches TIMEOUT, go to IDLE and pulse TimeoutP.
//     The next edge also sets Count=0 and discards the partial frame.
//   - BitR=1: shift in BitY, timer=0, Count+1.
//   - If this strobe is bit number WIDTH: load Data with the full word, Valid=1,
//     Count=0, go to HOLD.
//   - Latency: Valid rises on the edge that samples the last BitR.
//  Bit order:
//   - MSB_FIRST=1: shift left, new bit enters the LSB.
//   - MSB_FIRST=0: shift right, new bit enters the MSB.
//  HOLD:
//   - Valid=1 and Data stays frozen until Valid&Ready.
//   - Valid&Ready with BitR=0: Valid=0, go to IDLE.
//   - Valid&Ready with BitR=1 on the same edge: Valid=0, the strobe starts a new frame
//     (Count=1, go to COLLECT). This strobe is not an overrun.
//   - BitR=1 without Ready: bit dropped, Overrun=1, stay in HOLD.
//   - No timer runs in HOLD.
//  Clr=1 (any state): go to IDLE, Valid=0, Count=0, Overrun=0, timer=0.
//   BitR on the same edge is ignored. Data keeps its last value.
//  Overrun clears only on aR or Clr.
//  Ready with Valid=0 has no effect.
//  TimeoutP and a strobe never coincide: a strobe resets the timer first.
// TESTING
//  1 WIDTH=8, MSB_FIRST=1, Ready=1, strobes with Y=1,0,1,0,0,1,0,1, one per 3 cycles
//    -> Valid for 1 cycle, Data=8'hA5, Busy=0 afterwards.
//  2 MSB_FIRST=0, same bit stream -> Data=8'hA5 bit-reversed = 8'hA5.
//    Then stream 1,1,0,0,0,0,0,0 -> Data=8'h03.
//  3 Ready=0 after a full frame, 2 extra strobes -> Data unchanged, Overrun=1.
//    Ready=1 -> Valid=0. Clr -> Overrun=0.
//  4 TIMEOUT=10: 3 strobes then 10 idle cycles -> TimeoutP=1 for exactly 1 cycle,
//    Count=0. The next full frame assembles correctly.
//  5 Valid&Ready and BitR on the same edge -> Valid=0, Busy=1, Count=1, Overrun stays 0.
//  6 aR pulsed mid-frame (Count=5) and during HOLD -> all outputs 0 immediately.
//    BitY=X with BitR=0 never corrupts Data.

Source files
------------

// File: rtl/mealy_frame_collector_if.sv
// Bit-stream / word-handshake bundle between the serial decoder side,
// the word consumer and the frame collector.
interface mealy_frame_collector_if #(
    parameter int unsigned WIDTH = 8
);
    logic             BitR;
    logic             BitY;
    logic             Clr;
    logic             Ready;
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic             Busy;
    logic [4:0]       Count;
    logic             Overrun;
    logic             TimeoutP;

    // Decoder/consumer side: drives strobes, abort and acceptance.
    modport master (
        output BitR, BitY, Clr, Ready,
        input  Data, Valid, Busy, Count, Overrun, TimeoutP
    );

    // Collector side.
    modport slave (
        input  BitR, BitY, Clr, Ready,
        output Data, Valid, Busy, Count, Overrun, TimeoutP
    );
endinterface

// File: rtl/mealy_frame_collector.sv
// Frame collector behind the serial strobe/data decoder: assembles WIDTH
// strobed bits into a word, offers it with Valid/Ready, drops stalled frames
// on inter-bit timeout and flags strobes lost while a word is held.
module mealy_frame_collector #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                     C,
    input logic                     aR,
    mealy_frame_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [16:0] TO_LIM   = 17'(TIMEOUT);
    localparam logic [4:0]  LAST_CNT = 5'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             valid_q, valid_n;
    logic             busy_q, busy_n;
    logic             ovr_q, ovr_n;
    logic             to_q, to_n;
    logic [4:0]       count_q, count_n;
    logic [15:0]      timer_q, timer_n;

    logic [16:0]      timer_inc;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;

    // Insert one received bit according to the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    assign timer_inc = {1'b0, timer_q} + 17'd1;
    assign shifted   = shift_in(shreg, bus.BitY);
    assign fresh     = shift_in('0, bus.BitY);

    // State register.
    always_ff @(posedge C or posedge aR) begin
        if (aR)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state and next-register values; Clr outranks timeout, which outranks strobes.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        data_n  = data_q;
        valid_n = valid_q;
        count_n = count_q;
        ovr_n   = ovr_q;
        to_n    = 1'b0;
        timer_n = timer_q;

        if (bus.Clr) begin
            state_n = IDLE;
            shreg_n = '0;
            valid_n = 1'b0;
            count_n = '0;
            ovr_n   = 1'b0;
            timer_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.BitR) begin
                        shreg_n = fresh;
                        count_n = 5'd1;
                        timer_n = '0;
                        state_n = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!bus.BitR) begin
                        if (timer_inc == TO_LIM) begin
                            state_n = IDLE;
                            to_n    = 1'b1;
                            count_n = '0;
                            shreg_n = '0;
                            timer_n = '0;
                        end else begin
                            timer_n = timer_inc[15:0];
                        end
                    end else begin
                        timer_n = '0;
                        if (count_q == LAST_CNT) begin
                            data_n  = shifted;
                            valid_n = 1'b1;
                            count_n = '0;
                            shreg_n = '0;
                            state_n = HOLD;
                        end else begin
                            shreg_n = shifted;
                            count_n = count_q + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.Ready) begin
                        valid_n = 1'b0;
                        if (bus.BitR) begin
                            // Strobe coinciding with acceptance opens the next frame.
                            shreg_n = fresh;
                            count_n = 5'd1;
                            timer_n = '0;
                            state_n = COLLECT;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (bus.BitR) begin
                        ovr_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        busy_n = (state_n == COLLECT);
    end

    // Datapath and output registers.
    always_ff @(posedge C or posedge aR) begin
        if (aR) begin
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            ovr_q   <= ovr_n;
            to_q    <= to_n;
            count_q <= count_n;
            timer_q <= timer_n;
        end
    end

    assign bus.Data     = data_q;
    assign bus.Valid    = valid_q;
    assign bus.Busy     = busy_q;
    assign bus.Count    = count_q;
    assign bus.Overrun  = ovr_q;
    assign bus.TimeoutP = to_q;

endmodule
